alu64bit_mc: RTL



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu16_slice.sv | 41 ++++
 rtl/alu64bit_mc.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and sizing for the multi-cycle 64-bit ALU.
// Defines the op encoding, the FSM state encoding and the slice geometry.
// Imported by alu16_slice and alu64bit_mc.
package alu_pkg;

    localparam int SLICE_W  = 16;
    localparam int N_SLICES = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu16_slice.sv
// Combinational 16-bit ALU slice: ADD, SUB (a + ~b + cin), XOR, NOR.
// Ports: a/b operand slices, cin slice carry-in, op operation; s slice result, cout slice carry-out.
// Logic ops report cout=0 so the final carry of a logic op is always zero.
module alu16_slice
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  op_t                op,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] w_sum;

    always_comb begin
        w_sum = '0;
        s     = '0;
        cout  = 1'b0;
        unique case (op)
            OP_ADD: begin
                w_sum = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
                s     = w_sum[SLICE_W-1:0];
                cout  = w_sum[SLICE_W];
            end
            OP_SUB: begin
                w_sum = {1'b0, a} + {1'b0, ~b} + {{SLICE_W{1'b0}}, cin};
                s     = w_sum[SLICE_W-1:0];
                cout  = w_sum[SLICE_W];
            end
            OP_XOR: s = a ^ b;
            OP_NOR: s = ~(a | b);
            default: begin
                s    = '0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu64bit_mc.sv
// Multi-cycle 64-bit ALU: one 16-bit slice per cycle, carry held in a register between slices.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + a, b, cin, op in; out_valid/out_ready + s, cout out.
// Latency 4 cycles accept-to-out_valid; one op in flight, result held stable until out_ready.
module alu64bit_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 64  // must equal SLICE_W*N_SLICES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    op_t                r_op;
    logic               r_carry;
    logic [1:0]         r_k;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [SLICE_W-1:0] w_sl_a;
    logic [SLICE_W-1:0] w_sl_b;
    logic [SLICE_W-1:0] w_sl_s;
    logic               w_sl_cout;

    // Operand slice selected by the slice counter feeds the single shared slice.
    always_comb begin
        w_sl_a = '0;
        w_sl_b = '0;
        unique case (r_k)
            2'd0: begin w_sl_a = r_a[15:0];  w_sl_b = r_b[15:0];  end
            2'd1: begin w_sl_a = r_a[31:16]; w_sl_b = r_b[31:16]; end
            2'd2: begin w_sl_a = r_a[47:32]; w_sl_b = r_b[47:32]; end
            2'd3: begin w_sl_a = r_a[63:48]; w_sl_b = r_b[63:48]; end
            default: begin w_sl_a = '0; w_sl_b = '0; end
        endcase
    end

    alu16_slice u_slice (
        .a    (w_sl_a),
        .b    (w_sl_b),
        .cin  (r_carry),
        .op   (r_op),
        .s    (w_sl_s),
        .cout (w_sl_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_carry     <= 1'b0;
            r_k         <= 2'd0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_op       <= op_t'(op);
                        r_carry    <= cin;
                        r_k        <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_s[r_k*SLICE_W +: SLICE_W] <= w_sl_s;
                    r_carry <= w_sl_cout;
                    // Counter wraps 3->0 on the last slice, leaving it ready for the next op.
                    r_k     <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        r_cout      <= w_sl_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;

endmodule
